activation_unit: RTL

Multi-lane, runtime-configurable activation and requantization stage for the accumulator output path. Each beat carries LANES signed accumulator words. Every lane gets the selected activation (passthrough, ReLU, clamped ReLU, leaky ReLU), then a rounding right shift, then saturation to OUT_W. The block sits between the accumulator drain and the unified buffer write port, with full valid/ready backpressure, and counts saturation events for software profiling.

---
 rtl/tpu_act_pkg.sv | 23 ++
 rtl/act_lane.sv | 65 ++++++
 rtl/activation_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/tpu_act_pkg.sv
// Shared types and constants for the activation/requantization stage.
// The config struct describes both the live config and the snapshot that travels with a beat.
package tpu_act_pkg;

  localparam int CFG_IN_W    = 32;
  localparam int CFG_SHIFT_W = $clog2(CFG_IN_W);

  localparam logic [CFG_IN_W-1:0] DEFAULT_CLAMP = CFG_IN_W'(6);

  typedef enum logic [1:0] {
    ACT_PASS  = 2'b00,
    ACT_RELU  = 2'b01,
    ACT_CLAMP = 2'b10,
    ACT_LEAKY = 2'b11
  } act_mode_e;

  typedef struct packed {
    act_mode_e                mode;
    logic [CFG_IN_W-1:0]      clamp;
    logic [CFG_SHIFT_W-1:0]   shift;
  } act_cfg_t;

endpackage

// File: rtl/act_lane.sv
// Combinational per-lane datapath: activation, round-half-up right shift, saturation.
// Purely combinational; the pipeline registers live in activation_unit.
module act_lane
  import tpu_act_pkg::*;
#(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 8,
  parameter int LEAK_SHIFT = 3,
  localparam int SW        = $clog2(IN_W)
) (
  input  logic [IN_W-1:0]  x_i,
  input  act_mode_e        mode_i,
  input  logic [IN_W-1:0]  clamp_i,
  input  logic [SW-1:0]    shift_i,
  output logic [OUT_W-1:0] value_o,
  output logic             sat_o
);

  localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] x_s;
  logic signed [IN_W-1:0] clamp_s;
  logic signed [IN_W-1:0] act_v;
  logic signed [IN_W:0]   ext_v;
  logic        [IN_W:0]   half_v;
  logic signed [IN_W:0]   sum_v;
  logic signed [IN_W:0]   rnd_v;

  always_comb begin
    x_s     = signed'(x_i);
    // Clamp ceiling is always treated as non-negative.
    clamp_s = signed'(clamp_i & {1'b0, {(IN_W-1){1'b1}}});

    act_v = x_s;
    unique case (mode_i)
      ACT_PASS:  act_v = x_s;
      ACT_RELU:  if (x_s < 0) act_v = '0;
      ACT_CLAMP: begin
        if (x_s < 0)             act_v = '0;
        else if (x_s > clamp_s)  act_v = clamp_s;
      end
      ACT_LEAKY: if (x_s < 0) act_v = x_s >>> LEAK_SHIFT;
      default:   act_v = x_s;
    endcase

    // One extra bit of headroom so the rounding offset never overflows.
    ext_v  = {act_v[IN_W-1], act_v};
    half_v = (IN_W+1)'(1) << (shift_i - SW'(1));
    sum_v  = ext_v;
    if (shift_i != '0) sum_v = ext_v + signed'(half_v);
    rnd_v  = sum_v >>> shift_i;

    sat_o   = 1'b0;
    value_o = rnd_v[OUT_W-1:0];
    if (rnd_v > SAT_MAX) begin
      sat_o   = 1'b1;
      value_o = SAT_MAX[OUT_W-1:0];
    end else if (rnd_v < SAT_MIN) begin
      sat_o   = 1'b1;
      value_o = SAT_MIN[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/activation_unit.sv
// Two-stage valid/ready activation + requantization pipeline with per-beat config snapshot
// and a sticky saturation event counter.
module activation_unit
  import tpu_act_pkg::*;
#(
  parameter int         LANES       = 4,
  parameter int         IN_W        = CFG_IN_W,
  parameter int         OUT_W       = 8,
  parameter logic [1:0] DEFAULT_ACT = 2'b01,
  parameter int         LEAK_SHIFT  = 3,
  parameter int         SAT_CNT_W   = 16,
  localparam int        SW          = $clog2(IN_W)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_mode,
  input  logic [IN_W-1:0]        cfg_clamp,
  input  logic [SW-1:0]          cfg_shift,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  input  logic                   sat_clr,
  output logic [SAT_CNT_W-1:0]   sat_count
);

  localparam int NSAT_W = $clog2(LANES + 1);

  localparam act_cfg_t CFG_RESET = '{
    mode:  act_mode_e'(DEFAULT_ACT),
    clamp: DEFAULT_CLAMP,
    shift: '0
  };

  act_cfg_t                 cfg_q;
  act_cfg_t                 cfg_d;
  logic                     s1_valid_q;
  logic [LANES*IN_W-1:0]    s1_data_q;
  act_cfg_t                 s1_cfg_q;
  logic                     out_valid_q;
  logic [LANES*OUT_W-1:0]   out_data_q;
  logic [SAT_CNT_W-1:0]     sat_count_q;
  logic [SAT_CNT_W-1:0]     sat_count_d;

  logic                     out_advance;
  logic [LANES*OUT_W-1:0]   lane_out;
  logic [LANES-1:0]         lane_sat;
  logic [NSAT_W-1:0]        sat_lanes;
  logic [SAT_CNT_W:0]       sat_sum;

  // The output register frees up when empty or being drained; stage 1 can then move.
  assign out_advance = !out_valid_q || out_ready;
  assign in_ready    = !s1_valid_q || out_advance;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_count = sat_count_q;

  always_comb begin
    cfg_d       = cfg_q;
    cfg_d.mode  = act_mode_e'(cfg_mode);
    cfg_d.clamp = CFG_IN_W'(cfg_clamp);
    cfg_d.shift = CFG_SHIFT_W'(cfg_shift);
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    act_lane #(
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .x_i     (s1_data_q[gi*IN_W +: IN_W]),
      .mode_i  (s1_cfg_q.mode),
      .clamp_i (IN_W'(s1_cfg_q.clamp)),
      .shift_i (SW'(s1_cfg_q.shift)),
      .value_o (lane_out[gi*OUT_W +: OUT_W]),
      .sat_o   (lane_sat[gi])
    );
  end

  always_comb begin
    sat_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      sat_lanes = sat_lanes + NSAT_W'(lane_sat[i]);
    end
    sat_sum     = {1'b0, sat_count_q} + (SAT_CNT_W+1)'(sat_lanes);
    sat_count_d = sat_sum[SAT_CNT_W] ? '1 : sat_sum[SAT_CNT_W-1:0];
    // Clear takes priority over an increment landing in the same cycle.
    if (sat_clr)                          sat_count_d = '0;
    else if (!(s1_valid_q && out_advance)) sat_count_d = sat_count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q      <= CFG_RESET;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_cfg_q   <= CFG_RESET;
    end else begin
      if (cfg_we) cfg_q <= cfg_d;
      if (in_ready) begin
        s1_valid_q <= in_valid;
        // Snapshot the pre-edge config so a same-cycle write only affects later beats.
        if (in_valid) begin
          s1_data_q <= in_data;
          s1_cfg_q  <= cfg_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_count_q <= '0;
    end else begin
      if (out_advance) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) out_data_q <= lane_out;
      end
      sat_count_q <= sat_count_d;
    end
  end

endmodule
